// File: rtl/dcache_resp_unit.sv
// MEM-stage data-access responder with a direct-mapped, one-word-per-line, write-through,
// no-write-allocate data cache. Defining DCACHE_STAT_EN adds stat_hit/stat_miss counters.
module dcache_resp_unit #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_rd,
    input  logic        req_cacop,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    input  logic        req_uncached,
    input  logic        flush,
    output logic        resp_ok,
    output logic [31:0] resp_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_STAT_EN
    ,
    output logic [31:0] stat_hit,
    output logic [31:0] stat_miss
`endif
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 32 - INDEX_BITS - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_RD,
        S_MEM_WR,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_LD,
        OP_ST,
        OP_CACOP
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [31:2]         addr_q, addr_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                unc_q, unc_d;
    logic                cancel_q, cancel_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_ok_q, resp_ok_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [3:0]          mem_wstrb_q, mem_wstrb_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [31:0]           line_rd;
    logic                  hit;
    logic                  arr_we;
    logic [31:0]           arr_wdata;
    logic                  inval_en;
    logic [31:0]           merged;
    logic                  unused_addr_lsb;

    // The low address bits are always zero on a word-aligned request.
    assign unused_addr_lsb = ^req_addr[1:0];

    assign idx     = addr_q[INDEX_BITS+1:2];
    assign tag     = addr_q[31:INDEX_BITS+2];
    assign line_rd = data_q[idx];
    assign hit     = !unc_q && valid_q[idx] && (tag_q[idx] == tag);

    // Next-state, array-write and output logic.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        unc_d        = unc_q;
        cancel_d     = cancel_q;
        resp_ok_d    = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        arr_we       = 1'b0;
        arr_wdata    = mem_rdata;
        inval_en     = 1'b0;
        merged       = line_rd;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && (req_we || req_rd || req_cacop)) begin
                    op_d    = req_cacop ? OP_CACOP : (req_we ? OP_ST : OP_LD);
                    addr_d  = req_addr[31:2];
                    wstrb_d = req_wstrb;
                    wdata_d = req_wdata;
                    unc_d   = req_uncached;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (op_q == OP_CACOP) begin
                    inval_en = 1'b1;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_RESP;
                        resp_ok_d = 1'b1;
                    end
                end else if (flush) begin
                    state_d = S_IDLE;
                end else if (op_q == OP_LD) begin
                    if (hit) begin
                        state_d      = S_RESP;
                        resp_ok_d    = 1'b1;
                        resp_rdata_d = line_rd;
                    end else begin
                        state_d     = S_MEM_RD;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {addr_q, 2'b00};
                        mem_wstrb_d = 4'b0000;
                        mem_wdata_d = 32'd0;
                    end
                end else begin
                    if (hit) begin
                        arr_we    = 1'b1;
                        arr_wdata = merged;
                    end
                    state_d     = S_MEM_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {addr_q, 2'b00};
                    mem_wstrb_d = wstrb_q;
                    mem_wdata_d = wdata_q;
                end
            end
            S_MEM_RD, S_MEM_WR: begin
                if (flush) cancel_d = 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    // A cached fill lands even when the response is cancelled.
                    if ((state_q == S_MEM_RD) && !unc_q) begin
                        arr_we    = 1'b1;
                        arr_wdata = mem_rdata;
                    end
                    if (cancel_q || flush) begin
                        state_d  = S_IDLE;
                        cancel_d = 1'b0;
                    end else begin
                        state_d   = S_RESP;
                        resp_ok_d = 1'b1;
                        if (state_q == S_MEM_RD) resp_rdata_d = mem_rdata;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LD;
            addr_q       <= 30'd0;
            wstrb_q      <= 4'd0;
            wdata_q      <= 32'd0;
            unc_q        <= 1'b0;
            cancel_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_ok_q    <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wstrb_q  <= 4'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            unc_q        <= unc_d;
            cancel_q     <= cancel_d;
            req_ready_q  <= req_ready_d;
            resp_ok_q    <= resp_ok_d;
            resp_rdata_q <= resp_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Valid bits are the only array state that reset must clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (inval_en) begin
            valid_q[idx] <= 1'b0;
        end else if (arr_we) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= arr_wdata;
        end
    end

`ifdef DCACHE_STAT_EN
    logic [31:0] stat_hit_q, stat_miss_q;
    logic        hit_evt, miss_evt;

    assign hit_evt  = (state_q == S_LOOKUP) && (op_q == OP_LD) && !flush && hit;
    assign miss_evt = (state_q == S_LOOKUP) && (op_q == OP_LD) && !flush && !hit && !unc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_hit_q  <= 32'd0;
            stat_miss_q <= 32'd0;
        end else begin
            if (hit_evt)  stat_hit_q  <= stat_hit_q + 32'd1;
            if (miss_evt) stat_miss_q <= stat_miss_q + 32'd1;
        end
    end

    assign stat_hit  = stat_hit_q;
    assign stat_miss = stat_miss_q;
`endif

    assign req_ready  = req_ready_q;
    assign resp_ok    = resp_ok_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dcache_resp_unit.sv
// Self-checking bench for dcache_resp_unit: directed scenarios plus random traffic
// checked against a transaction-level cache model.
module tb_dcache_resp_unit;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_rd, req_cacop, req_uncached, flush;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_ok;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
`ifdef DCACHE_STAT_EN
    logic [31:0] stat_hit, stat_miss;
    int          m_hit, m_miss;
`endif

    int n_cmp;
    int n_bad;

    // Transaction-level model of the 64-line cache.
    bit          v_m [64];
    logic [23:0] t_m [64];
    logic [31:0] d_m [64];

    dcache_resp_unit #(.INDEX_BITS(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_rd       (req_rd),
        .req_cacop    (req_cacop),
        .req_addr     (req_addr),
        .req_wstrb    (req_wstrb),
        .req_wdata    (req_wdata),
        .req_uncached (req_uncached),
        .flush        (flush),
        .resp_ok      (resp_ok),
        .resp_rdata   (resp_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
`ifdef DCACHE_STAT_EN
        ,
        .stat_hit     (stat_hit),
        .stat_miss    (stat_miss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // op: 0 load, 1 store, 2 cacop. flush_at: -1 none, 0 during lookup,
    // k>0 during the k-th cycle of mem_req. ack_d: idle mem_req cycles before ack.
    task automatic run_txn(input string name, input int op, input logic [31:0] addr,
                           input logic [3:0] ws, input logic [31:0] wd, input bit unc,
                           input int flush_at, input int ack_d, input logic [31:0] rword);
        int          idx;
        logic [23:0] tg;
        bit          hit, lk_flush, exp_mem, exp_resp, prev_req, ack_given, drop, seen_mem;
        int          cyc, mcnt, ack_cyc, resp_cyc, ready_cyc, resp_cnt;
        logic [31:0] got_rdata, exp_rdata;

        idx      = int'(addr[7:2]);
        tg       = addr[31:8];
        hit      = !unc && v_m[idx] && (t_m[idx] == tg);
        lk_flush = (flush_at == 0);
        exp_mem  = (op != 2) && !lk_flush && (op == 1 || !hit);
        exp_resp = (op == 2) ? !lk_flush : (!lk_flush && !(exp_mem && flush_at > 0));
        exp_rdata = hit ? d_m[idx] : rword;

        @(negedge clk);
        chk({name, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_rd    = (op == 0);
        req_we    = (op == 1);
        req_cacop = (op == 2);
        req_addr  = addr;
        req_wstrb = ws;
        req_wdata = wd;
        req_uncached = unc;
        @(negedge clk);
        req_valid = 1'b0;
        req_rd = 1'b0; req_we = 1'b0; req_cacop = 1'b0;
        flush = lk_flush;
        cyc = 1; mcnt = 0; ack_cyc = -1; resp_cyc = -1; ready_cyc = -1; resp_cnt = 0;
        prev_req = 1'b0; ack_given = 1'b0; drop = 1'b0; seen_mem = 1'b0;
        got_rdata = 32'd0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            flush   = 1'b0;
            mem_ack = 1'b0;
            if (prev_req && !mem_req && !ack_given) drop = 1'b1;
            prev_req = mem_req;
            if (mem_req) begin
                mcnt++;
                if (mcnt == 1) begin
                    seen_mem = 1'b1;
                    chk({name, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                    chk({name, ".mem_we"}, 32'(mem_we), 32'(op == 1));
                    if (op == 1) begin
                        chk({name, ".mem_wstrb"}, 32'(mem_wstrb), 32'(ws));
                        chk({name, ".mem_wdata"}, mem_wdata, wd);
                    end
                end
                if (mcnt == flush_at) flush = 1'b1;
                if (mcnt == ack_d + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rword;
                    ack_given = 1'b1;
                    ack_cyc   = cyc;
                end
            end
            if (resp_ok) begin
                resp_cnt++;
                resp_cyc  = cyc;
                got_rdata = resp_rdata;
            end
            if (req_ready) begin
                ready_cyc = cyc;
                break;
            end
        end
        mem_ack = 1'b0;
        flush   = 1'b0;

        chk({name, ".returned_idle"}, 32'(ready_cyc > 0), 32'd1);
        chk({name, ".mem_issued"}, 32'(seen_mem), 32'(exp_mem));
        chk({name, ".resp_count"}, 32'(resp_cnt), 32'(exp_resp));
        if (exp_resp && op == 0) chk({name, ".rdata"}, got_rdata, exp_rdata);
        if (exp_resp && !exp_mem) chk({name, ".resp_latency"}, 32'(resp_cyc), 32'd2);
        if (exp_mem) begin
            chk({name, ".ready_after_ack"}, 32'(ready_cyc - ack_cyc), exp_resp ? 32'd2 : 32'd1);
            chk({name, ".req_held"}, 32'(drop), 32'd0);
        end

        if (op == 2) begin
            v_m[idx] = 1'b0;
        end else if (op == 1 && !lk_flush && hit) begin
            for (int b = 0; b < 4; b++)
                if (ws[b]) d_m[idx][8*b +: 8] = wd[8*b +: 8];
        end else if (op == 0 && exp_mem && !unc) begin
            v_m[idx] = 1'b1;
            t_m[idx] = tg;
            d_m[idx] = rword;
        end
`ifdef DCACHE_STAT_EN
        if (op == 0 && !lk_flush && hit) m_hit++;
        if (op == 0 && !lk_flush && !hit && !unc) m_miss++;
`endif
    endtask

    initial begin
        int guard;
        int op, fa, ad;
        logic [31:0] a;
        logic [7:0]  tsel;

        n_cmp = 0; n_bad = 0;
`ifdef DCACHE_STAT_EN
        m_hit = 0; m_miss = 0;
`endif
        for (int i = 0; i < 64; i++) begin v_m[i] = 1'b0; t_m[i] = '0; d_m[i] = '0; end
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_rd = 1'b0; req_cacop = 1'b0;
        req_addr = '0; req_wstrb = '0; req_wdata = '0; req_uncached = 1'b0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.resp_ok", 32'(resp_ok), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_txn("ld_miss",     0, 32'h0000_1000, 4'h0, 32'h0, 1'b0, -1, 0, 32'hDEAD_BEEF);
        run_txn("ld_hit",      0, 32'h0000_1000, 4'h0, 32'h0, 1'b0, -1, 0, 32'h0);
        run_txn("st_hit",      1, 32'h0000_1000, 4'b0011, 32'h0000_CAFE, 1'b0, -1, 1, 32'h0);
        run_txn("ld_merged",   0, 32'h0000_1000, 4'h0, 32'h0, 1'b0, -1, 0, 32'h0);
        chk("model.merged", d_m[0], 32'hDEAD_CAFE);
        run_txn("ld_unc",      0, 32'h0000_1000, 4'h0, 32'h0, 1'b1, -1, 2, 32'h1111_1111);
        run_txn("ld_after_unc",0, 32'h0000_1000, 4'h0, 32'h0, 1'b0, -1, 0, 32'h0);
        run_txn("cacop",       2, 32'h0000_1000, 4'h0, 32'h0, 1'b0, -1, 0, 32'h0);
        run_txn("ld_after_inv",0, 32'h0000_1000, 4'h0, 32'h0, 1'b0, -1, 0, 32'h2222_3333);
        run_txn("flush_memrd", 0, 32'h0000_2004, 4'h0, 32'h0, 1'b0, 1, 3, 32'h4444_5555);
        run_txn("ld_filled",   0, 32'h0000_2004, 4'h0, 32'h0, 1'b0, -1, 0, 32'h0);
        run_txn("flush_lkup",  1, 32'h0000_2004, 4'hF, 32'h9999_9999, 1'b0, 0, 0, 32'h0);
        run_txn("ld_unchanged",0, 32'h0000_2004, 4'h0, 32'h0, 1'b0, -1, 0, 32'h0);
        run_txn("cacop_flush", 2, 32'h0000_2004, 4'h0, 32'h0, 1'b0, 0, 0, 32'h0);
        run_txn("ld_inv_flush",0, 32'h0000_2004, 4'h0, 32'h0, 1'b0, -1, 1, 32'h6666_7777);

        // Requests with no op bit and stray acks in IDLE are ignored.
        @(negedge clk);
        req_valid = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0; mem_ack = 1'b0;
        chk("noop.ready", 32'(req_ready), 32'd1);
        chk("noop.resp_ok", 32'(resp_ok), 32'd0);
        chk("noop.mem_req", 32'(mem_req), 32'd0);

        for (int n = 0; n < 80; n++) begin
            op   = int'($urandom_range(0, 2));
            case ($urandom_range(0, 2))
                0: tsel = 8'h10;
                1: tsel = 8'h20;
                default: tsel = 8'h31;
            endcase
            a    = {16'h0, tsel, 8'h00} | (32'($urandom_range(0, 3)) << 2);
            ad   = int'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: fa = 0;
                1: fa = int'($urandom_range(1, ad + 1));
                default: fa = -1;
            endcase
            run_txn("rand", op, a, 4'($urandom), $urandom, ($urandom_range(0, 4) == 0),
                    fa, ad, $urandom);
        end

`ifdef DCACHE_STAT_EN
        chk("stat_hit", stat_hit, 32'(m_hit));
        chk("stat_miss", stat_miss, 32'(m_miss));
`endif

        // Asynchronous reset in the middle of a memory write.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_1000;
        req_wstrb = 4'hF; req_wdata = 32'h1234_5678; req_uncached = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        guard = 0;
        while (!mem_req && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("rstmid.mem_req_seen", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rstmid.mem_req", 32'(mem_req), 32'd0);
        chk("rstmid.req_ready", 32'(req_ready), 32'd1);
        chk("rstmid.resp_ok", 32'(resp_ok), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 64; i++) v_m[i] = 1'b0;
`ifdef DCACHE_STAT_EN
        m_hit = 0; m_miss = 0;
`endif
        run_txn("ld_post_rst", 0, 32'h0000_1000, 4'h0, 32'h0, 1'b0, -1, 0, 32'hABCD_0001);
        run_txn("ld_post_rst2",0, 32'h0000_2004, 4'h0, 32'h0, 1'b0, -1, 0, 32'hABCD_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_resp_unit.md
Name: dcache_resp_unit

Overview:
- Responder for the MEM-stage data-access interface: accepts one load/store/cacop request at a time and returns a completion pulse plus load data.
- Holds a direct-mapped, one-word-per-line, write-through, no-write-allocate data cache.
- Uses a simple req/ack memory port for misses, uncached accesses and all stores.
- Sits between the MEM stage and the memory bus bridge.

Parameters:
INDEX_BITS, 6, line index width (2^INDEX_BITS lines of one 32-bit word); tag = addr[31:INDEX_BITS+2]

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (reset==0 clears state)
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_we  in  1  store
req_rd  in  1  load
req_cacop  in  1  invalidate line indexed by req_addr
req_addr  in  32  byte address (word-aligned; alignment checked upstream)
req_wstrb  in  4  store byte enables
req_wdata  in  32  store data
req_uncached  in  1  bypass cache
flush  in  1  pipeline flush; cancels the pending response
resp_ok  out  1  one-cycle completion pulse
resp_rdata  out  32  load word, valid while resp_ok=1
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  32  word address (addr[1:0]=0)
mem_wstrb  out  4  write byte enables
mem_wdata  out  32  write data
mem_ack  in  1  memory completion, one cycle
mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Reset: state=IDLE; all valid bits=0; req_ready=1; resp_ok=0, resp_rdata=0; mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0; cancel flag=0.
- Accept: in IDLE, req_valid & req_ready & (req_we|req_rd|req_cacop) registers the request and moves to LOOKUP.
- Opcode priority: cacop > we > rd. A req_valid with no op bit set is ignored.
- LOOKUP, cacop: clear the valid bit at the index; resp_ok=1 next cycle (RESP); the tag is not compared.
- LOOKUP, load, cached hit: go to RESP with resp_rdata = stored word. Hit-load latency is 2 cycles (accept edge to resp_ok).
- LOOKUP, load, miss or uncached: go to MEM_RD.
- LOOKUP, store: if cached hit, merge req_wdata into the line per req_wstrb in this cycle. Then go to MEM_WR. No allocation on a store miss.
- MEM_RD / MEM_WR: mem_req=1 with stable addr/we/wstrb/wdata until the mem_ack cycle, then mem_req=0 and go to RESP.
- Load fill: on mem_ack, a cached load writes tag+data and sets valid. An uncached load never touches the array. resp_rdata = mem_rdata.
- RESP: resp_ok=1 for exactly one cycle, then IDLE. resp_rdata holds until the next response.
- Flush in IDLE: no effect.
- Flush in LOOKUP: the request is dropped, with no array update and no memory access. Exception: a cacop still completes its invalidate. Go to IDLE with no resp_ok.
- Flush in MEM_RD / MEM_WR: the bus transaction completes (mem_req is never withdrawn) and a fill still occurs. A cancel flag is set, and RESP is skipped (no resp_ok).
- A flush coincident with resp_ok does not suppress that pulse.
- mem_ack outside MEM_* is ignored.
- Asynchronous reset mid-transaction returns everything to reset values immediately. The memory side must tolerate the dropped request.

Optional Feature:
- Macro DCACHE_STAT_EN.
- Defined: adds outputs stat_hit[31:0] and stat_miss[31:0], both reset to 0.
  - stat_hit increments on each cached load hit in LOOKUP.
  - stat_miss increments on each cached load miss entering MEM_RD.
  - Neither counter increments for flush-cancelled requests; both wrap at 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Cached load 0x00001000 after reset → mem_req with mem_addr=0x00001000; mem_ack with mem_rdata=0xDEADBEEF → resp_ok with resp_rdata=0xDEADBEEF. Repeat the load → resp_ok 2 cycles after accept, no mem_req.
- Store wstrb=4'b0011, wdata=0x0000CAFE to 0x00001000 (hit) → mem_req we=1 wstrb=0011. Then load 0x00001000 → hit returns 0xDEADCAFE.
- Uncached load to 0x00001000 with mem_rdata=0x11111111 → resp_rdata=0x11111111. A following cached load still hits with 0xDEADCAFE.
- cacop at 0x00001000 → resp_ok with no mem_req. The next load to 0x00001000 misses and issues mem_req.
- Flush asserted during MEM_RD, mem_ack 3 cycles later → mem_req held until ack, no resp_ok, req_ready=1 next cycle, and the line is filled (the next load hits).
- reset pulled low during MEM_WR → mem_req=0 immediately, req_ready=1, all lines invalid.
